// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: on start, emits pulse_count pulses of
// high_len clocks separated by low_len clocks, then strobes done.
// Optional PULSE_GEN_SWEEP_EN: the high length grows by one per pulse (saturating).
module pulse_gen #(
  parameter int unsigned N_BITS = 8,
  parameter int unsigned N_CNT  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_BITS-1:0] high_len,
  input  logic [N_BITS-1:0] low_len,
  input  logic [N_CNT-1:0]  pulse_count,
  output logic              pulse_out,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] last_high
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

`ifdef PULSE_GEN_SWEEP_EN
  localparam logic [N_BITS-1:0] H_MAX = '1;
`endif

  state_t            state;
  state_t            state_next;

  logic [N_BITS-1:0] high_cur;   // width of the pulse in flight (already clamped)
  logic [N_BITS-1:0] low_lat;    // clamped gap length
  logic [N_BITS-1:0] high_cnt;
  logic [N_BITS-1:0] low_cnt;
  logic [N_CNT-1:0]  rem_cnt;

  logic              accept;
  logic              high_end;
  logic              low_end;
  logic              last_pulse;

  logic              pulse_d;
  logic              busy_d;
  logic              done_d;

  // Zero lengths are clamped so every phase lasts at least one clock.
  function automatic logic [N_BITS-1:0] clamp1(input logic [N_BITS-1:0] v);
    return (v == '0) ? N_BITS'(1) : v;
  endfunction

  always_comb begin
    accept     = (state == S_IDLE) && start;
    high_end   = (state == S_HIGH) && (high_cnt == '0);
    low_end    = (state == S_LOW)  && (low_cnt == '0);
    last_pulse = (rem_cnt == N_CNT'(1));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start && (pulse_count != '0)) begin
          state_next = S_HIGH;
        end
      end
      S_HIGH: begin
        if (high_cnt == '0) begin
          state_next = last_pulse ? S_IDLE : S_LOW;
        end
      end
      S_LOW: begin
        if (low_cnt == '0) begin
          state_next = S_HIGH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode; values are registered below so pulse_out follows the next state.
  always_comb begin
    pulse_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    pulse_d = (state_next == S_HIGH);
    busy_d  = (state_next != S_IDLE);
    done_d  = (accept && (pulse_count == '0)) || (high_end && last_pulse);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pulse_out <= pulse_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Burst datapath: latched lengths, phase counters and remaining-pulse count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_cur  <= '0;
      low_lat   <= '0;
      high_cnt  <= '0;
      low_cnt   <= '0;
      rem_cnt   <= '0;
      last_high <= '0;
    end else begin
      if (accept) begin
        high_cur <= clamp1(high_len);
        low_lat  <= clamp1(low_len);
        high_cnt <= clamp1(high_len) - N_BITS'(1);
        rem_cnt  <= pulse_count;
      end else if (state == S_HIGH) begin
        if (high_end) begin
          rem_cnt   <= rem_cnt - N_CNT'(1);
          last_high <= high_cur;
          low_cnt   <= low_lat - N_BITS'(1);
`ifdef PULSE_GEN_SWEEP_EN
          if (high_cur != H_MAX) begin
            high_cur <= high_cur + N_BITS'(1);
          end
`endif
        end else begin
          high_cnt <= high_cnt - N_BITS'(1);
        end
      end else if (state == S_LOW) begin
        if (low_end) begin
          high_cnt <= high_cur - N_BITS'(1);
        end else begin
          low_cnt <= low_cnt - N_BITS'(1);
        end
      end
    end
  end

  // Structural invariants of the registered outputs.
  a_pulse_implies_busy : assert property (@(posedge clk) disable iff (reset)
    pulse_out |-> busy);
  a_done_is_idle : assert property (@(posedge clk) disable iff (reset)
    done |-> (!busy && !pulse_out));

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: burst shapes, zero lengths/count, busy starts,
// back-to-back, async reset, long bursts and (with PULSE_GEN_SWEEP_EN) width sweep.
module tb_pulse_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [7:0] pulse_count;
  logic       pulse_out;
  logic       busy;
  logic       done;
  logic [7:0] last_high;

  int checks   = 0;
  int failures = 0;

  pulse_gen #(.N_BITS(8), .N_CNT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .high_len    (high_len),
    .low_len     (low_len),
    .pulse_count (pulse_count),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .last_high   (last_high)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start, then trace ncyc cycles; first traced cycle lands in the MSB.
  task automatic burst(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n,
                       input int ncyc,
                       output logic [63:0] p, output logic [63:0] d, output logic [63:0] b);
    high_len = h; low_len = l; pulse_count = n; start = 1'b1;
    p = '0; d = '0; b = '0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      start = 1'b0;
      p = {p[62:0], pulse_out};
      d = {d[62:0], done};
      b = {b[62:0], busy};
    end
  endtask

  // Run a burst to done, measuring pulse widths and the start-to-done latency.
  task automatic measure(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n,
                         output int np, output int maxw, output int cyc,
                         output int w0, output int w1, output int w2);
    int  run;
    bit  got_done;
    high_len = h; low_len = l; pulse_count = n; start = 1'b1;
    np = 0; maxw = 0; cyc = 0; w0 = 0; w1 = 0; w2 = 0; run = 0; got_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      start = 1'b0;
      cyc++;
      if (pulse_out) begin
        run++;
      end else if (run > 0) begin
        if (np == 0) w0 = run;
        if (np == 1) w1 = run;
        if (np == 2) w2 = run;
        if (run > maxw) maxw = run;
        np++;
        run = 0;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    check("measure_done_seen", 64'(got_done), 64'd1);
  endtask

  logic [63:0] p, d, b;
  int np, maxw, cyc, w0, w1, w2;
  bit saw_done;

  initial begin
    reset = 1'b1; start = 1'b0; high_len = '0; low_len = '0; pulse_count = '0;
    tick(); tick();
    check("rst_pulse_out", 64'(pulse_out), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_last_high", 64'(last_high), 64'd0);
    reset = 1'b0;
    tick();

    // Basic burst H=3 L=2 N=2: high t+1..t+3, t+6..t+8, done at t+9.
    burst(8'd3, 8'd2, 8'd2, 10, p, d, b);
    check("basic_pulse", p, 64'b1110011100);
    check("basic_done",  d, 64'b0000000010);
    check("basic_busy",  b, 64'b1111111100);
    check("basic_last_high", 64'(last_high), 64'd3);

    // Zero lengths clamp to 1: 1 high / 1 low, done at t+6.
    burst(8'd0, 8'd0, 8'd3, 7, p, d, b);
    check("zero_len_pulse", p, 64'b1010100);
    check("zero_len_done",  d, 64'b0000010);
    check("zero_len_busy",  b, 64'b1111100);
    check("zero_len_last_high", 64'(last_high), 64'd1);

    // Zero count: done at t+1, no pulse, never busy.
    burst(8'd4, 8'd4, 8'd0, 3, p, d, b);
    check("zero_cnt_pulse", p, 64'b000);
    check("zero_cnt_done",  d, 64'b100);
    check("zero_cnt_busy",  b, 64'b000);

    // Start held through a burst; inputs changed mid-burst are ignored until the done-cycle start.
    high_len = 8'd2; low_len = 8'd1; pulse_count = 8'd2; start = 1'b1;
    p = '0; d = '0; b = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) high_len = 8'd1;
      if (i == 6) start = 1'b0;
      p = {p[62:0], pulse_out};
      d = {d[62:0], done};
      b = {b[62:0], busy};
    end
    check("b2b_pulse", p, 64'b1101101010);
    check("b2b_done",  d, 64'b0000010001);
    check("b2b_busy",  b, 64'b1111101110);
    check("b2b_last_high", 64'(last_high), 64'd1);

    // Reset during the high phase of pulse 1 of 4 (H=3 L=2).
    high_len = 8'd3; low_len = 8'd2; pulse_count = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("mid_pulse_high",     64'(pulse_out), 64'd1);
    check("mid_last_high_pre",  64'(last_high), 64'd3);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_pulse_out", 64'(pulse_out), 64'd0);
    check("mid_rst_busy",      64'(busy),      64'd0);
    check("mid_rst_last_high", 64'(last_high), 64'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    check("mid_rst_no_done", 64'(saw_done), 64'd0);
    burst(8'd3, 8'd2, 8'd2, 10, p, d, b);
    check("post_rst_pulse", p, 64'b1110011100);
    check("post_rst_done",  d, 64'b0000000010);

    // Loopback-style max width: H=5 L=3 N=4.
    measure(8'd5, 8'd3, 8'd4, np, maxw, cyc, w0, w1, w2);
    check("loop_npulses", 64'(np), 64'd4);
`ifdef PULSE_GEN_SWEEP_EN
    check("loop_max_width", 64'(maxw), 64'd8);
    check("loop_last_high", 64'(last_high), 64'd8);
`else
    check("loop_max_width", 64'(maxw), 64'd5);
    check("loop_last_high", 64'(last_high), 64'd5);
`endif

    // Full-scale count of 255 single-clock pulses: done at 1+255+254 = 510.
    tick();
    measure(8'd1, 8'd1, 8'd255, np, maxw, cyc, w0, w1, w2);
    check("max_cnt_npulses", 64'(np),   64'd255);
    check("max_cnt_latency", 64'(cyc),  64'd510);
    check("max_cnt_width",   64'(maxw), 64'd1);

    // Wide pulses near the top of the length range.
    tick();
    measure(8'd254, 8'd1, 8'd3, np, maxw, cyc, w0, w1, w2);
    check("sat_w0", 64'(w0), 64'd254);
`ifdef PULSE_GEN_SWEEP_EN
    check("sat_w1", 64'(w1), 64'd255);
    check("sat_w2", 64'(w2), 64'd255);
    check("sat_latency", 64'(cyc), 64'd767);
    check("sat_last_high", 64'(last_high), 64'd255);
`else
    check("sat_w1", 64'(w1), 64'd254);
    check("sat_w2", 64'(w2), 64'd254);
    check("sat_latency", 64'(cyc), 64'd765);
    check("sat_last_high", 64'(last_high), 64'd254);
`endif

    tick();
    check("end_idle_busy", 64'(busy), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
